serial_comp_ctrl: RTL

Bit-serial magnitude comparator controller. It compares two unsigned WIDTH-bit words MSB-first using a single comp_1bit cell, one bit per clock. It stops at the first differing bit and returns registered agb/alb/aeb with a start/busy/done handshake. It serves wide compares where area matters more than latency, reusing the team's 1-bit comparator cell as the only compare datapath.

---
 rtl/serial_comp_ctrl_if.sv | 25 ++
 rtl/serial_comp_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/serial_comp_ctrl_if.sv
// rtl/serial_comp_ctrl_if.sv - start/operand/result bundle for the bit-serial comparator controller
interface serial_comp_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             agb;
   logic             alb;
   logic             aeb;
   logic [CW-1:0]    nbits;

   modport master (
      output start, a, b,
      input  busy, done, agb, alb, aeb, nbits
   );

   modport slave (
      input  start, a, b,
      output busy, done, agb, alb, aeb, nbits
   );
endinterface

// File: rtl/serial_comp_ctrl.sv
// rtl/serial_comp_ctrl.sv - MSB-first bit-serial magnitude comparator built around one comp_1bit cell
module comp_1bit (
   input  logic a_i,
   input  logic b_i,
   output logic gt_o,
   output logic lt_o,
   output logic eq_o
);
   assign gt_o = a_i & ~b_i;
   assign lt_o = ~a_i & b_i;
   assign eq_o = ~(a_i ^ b_i);
endmodule

module serial_comp_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH) + 1,
   localparam int IW    = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_comp_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] ra_q;
   logic [WIDTH-1:0] rb_q;
   logic [IW-1:0]    idx_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             agb_q;
   logic             alb_q;
   logic             aeb_q;
   logic [CW-1:0]    nbits_q;

   logic bit_gt;
   logic bit_lt;
   logic bit_eq;

   comp_1bit u_cell (
      .a_i  (ra_q[idx_q]),
      .b_i  (rb_q[idx_q]),
      .gt_o (bit_gt),
      .lt_o (bit_lt),
      .eq_o (bit_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         agb_q   <= 1'b0;
         alb_q   <= 1'b0;
         aeb_q   <= 1'b0;
         nbits_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  ra_q    <= bus.a;
                  rb_q    <= bus.b;
                  idx_q   <= IW'(WIDTH - 1);
                  cnt_q   <= '0;
                  agb_q   <= 1'b0;
                  alb_q   <= 1'b0;
                  aeb_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               cnt_q <= cnt_q + CW'(1);
               // First differing bit decides; all bits equal only once idx reaches 0.
               if (!bit_eq) begin
                  agb_q   <= bit_gt;
                  alb_q   <= bit_lt;
                  aeb_q   <= 1'b0;
                  nbits_q <= cnt_q + CW'(1);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (idx_q == '0) begin
                  aeb_q   <= 1'b1;
                  nbits_q <= CW'(WIDTH);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q - IW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.agb   = agb_q;
   assign bus.alb   = alb_q;
   assign bus.aeb   = aeb_q;
   assign bus.nbits = nbits_q;
endmodule
